// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Byte-serial instruction loader plus small instruction memory.
//             Bytes arriving in LOAD mode are packed little-endian into 32-bit
//             words and written at an auto-incrementing pointer. In RUN mode
//             the CPU fetches registered words addressed by its PC.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             load_en             - 1 requests LOAD, 0 requests RUN
//             byte_in/byte_valid  - instruction byte stream
//             fetch_addr          - CPU byte address
//             instr_out           - registered fetched word (NOP on miss)
//             fetch_misalign      - registered, fetch_addr[1:0] != 0
//             loaded_words, full  - complete words in this load / memory full
//             overflow            - sticky, a byte was dropped while full
//             partial_err         - sticky, load ended mid-word
//             load_done           - one-cycle pulse on LOAD->RUN
//             checksum            - XOR of loaded words (IMEM_CHECKSUM_EN)
//  Options  : define IMEM_CHECKSUM_EN to build the running XOR checksum;
//             otherwise checksum is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int          DEPTH    = 16,
  parameter int          ADDR_W   = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       instr_out,
  output logic              fetch_misalign,
  output logic [ADDR_W:0]   loaded_words,
  output logic              full,
  output logic              overflow,
  output logic              partial_err,
  output logic              load_done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_asm;        // lanes 0..2; lane 3 comes straight from byte_in
  logic [ADDR_W:0]   r_wr_ptr;     // one extra bit so it can reach DEPTH
  logic [31:0]       r_mem [DEPTH];

  logic              w_load_entry;
  logic              w_load_exit;
  logic              w_byte_in_load;
  logic              w_accept;
  logic              w_drop;
  logic              w_word_done;
  logic [31:0]       w_word;
  logic              w_fetch_hit;
  logic [ADDR_W-1:0] w_fetch_idx;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_load_entry   = 1'b0;
    w_load_exit    = 1'b0;
    w_byte_in_load = 1'b0;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (load_en) begin
          w_state_next = ST_LOAD;
          w_load_entry = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!load_en) begin
          // Leaving LOAD takes priority over any byte offered that cycle.
          w_state_next = ST_RUN;
          w_load_exit  = 1'b1;
        end else begin
          w_byte_in_load = byte_valid;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign full         = (r_wr_ptr == c_DEPTH);
  assign loaded_words = r_wr_ptr;
  assign w_accept     = w_byte_in_load && !full;
  assign w_drop       = w_byte_in_load && full;
  assign w_word_done  = w_accept && (r_byte_idx == 2'd3) && !rst;
  assign w_word       = {byte_in, r_asm};

  // --------------------------------------------------------------------------
  // Byte assembly, write pointer and status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_idx  <= 2'd0;
      r_asm       <= 24'd0;
      r_wr_ptr    <= '0;
      overflow    <= 1'b0;
      partial_err <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      load_done <= w_load_exit;
      if (w_load_entry) begin
        r_byte_idx  <= 2'd0;
        r_wr_ptr    <= '0;
        overflow    <= 1'b0;
        partial_err <= 1'b0;
      end else if (w_load_exit) begin
        if (r_byte_idx != 2'd0) partial_err <= 1'b1;
        r_byte_idx <= 2'd0;
      end else if (w_accept) begin
        case (r_byte_idx)
          2'd0:    r_asm[7:0]   <= byte_in;
          2'd1:    r_asm[15:8]  <= byte_in;
          2'd2:    r_asm[23:16] <= byte_in;
          default: r_asm        <= r_asm;
        endcase
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) r_wr_ptr <= r_wr_ptr + 1'b1;
      end else if (w_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Memory array carries no reset; loaded_words gates what is reachable.
  always_ff @(posedge clk) begin
    if (w_word_done) r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_word;
  end

  // --------------------------------------------------------------------------
  // Fetch port: one-cycle latency, NOP for anything not loaded and aligned
  // --------------------------------------------------------------------------
  assign w_fetch_idx = fetch_addr[ADDR_W+1:2];
  assign w_fetch_hit = (r_state == ST_RUN)
                    && (fetch_addr[1:0] == 2'b00)
                    && (fetch_addr[31:ADDR_W+2] == '0)
                    && ({1'b0, w_fetch_idx} < r_wr_ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out      <= NOP_WORD;
      fetch_misalign <= 1'b0;
    end else begin
      instr_out      <= w_fetch_hit ? r_mem[w_fetch_idx] : NOP_WORD;
      fetch_misalign <= (fetch_addr[1:0] != 2'b00);
    end
  end

  // --------------------------------------------------------------------------
  // Optional running checksum of words written in the current load
  // --------------------------------------------------------------------------
`ifdef IMEM_CHECKSUM_EN
  logic [31:0] r_checksum;
  always_ff @(posedge clk) begin
    if (rst)              r_checksum <= 32'h0;
    else if (w_load_entry) r_checksum <= 32'h0;
    else if (w_word_done)  r_checksum <= r_checksum ^ w_word;
  end
  assign checksum = r_checksum;
`else
  assign checksum = 32'h0;
`endif

endmodule
`default_nettype wire
